// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - shared op encodings, FSM states and sizing helper for the multiply/divide unit
package md_defs;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    function automatic int cnt_width(input int mult_cycles, input int div_cycles);
        int mx;
        mx = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return $clog2(mx + 1);
    endfunction

    function automatic logic is_long_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_arith.sv
// rtl/md_unit_arith.sv - combinational signed/unsigned multiply and divide producing hi/lo
module md_arith
    import md_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  md_op_e           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next,
    output logic             div_zero
);

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic               signed_div;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Signed divide runs on magnitudes so most-negative / -1 wraps cleanly instead of overflowing.
    assign signed_div = (op == MD_DIV);
    assign a_neg      = signed_div && a[WIDTH-1];
    assign b_neg      = signed_div && b[WIDTH-1];
    assign a_mag      = a_neg ? (WIDTH'(0) - a) : a;
    assign b_mag      = b_neg ? (WIDTH'(0) - b) : b;
    assign div_zero   = (b == '0);
    assign divisor    = div_zero ? WIDTH'(1) : b_mag;
    assign q_mag      = a_mag / divisor;
    assign r_mag      = a_mag % divisor;
    assign quot       = (a_neg ^ b_neg) ? (WIDTH'(0) - q_mag) : q_mag;
    assign rem        = a_neg ? (WIDTH'(0) - r_mag) : r_mag;

    always_comb begin
        hi_next = '0;
        lo_next = '0;
        case (op)
            MD_MULT:  {hi_next, lo_next} = prod_s;
            MD_MULTU: {hi_next, lo_next} = prod_u;
            MD_DIV, MD_DIVU: begin
                hi_next = rem;
                lo_next = quot;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
module md_unit
    import md_defs::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cnt_width(MULT_CYCLES, DIV_CYCLES);

    md_state_e        state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    md_op_e           op_q, op_n;
    logic [WIDTH-1:0] a_q, a_n;
    logic [WIDTH-1:0] b_q, b_n;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic             busy_n, done_n;
    md_op_e           op_in;

    logic [WIDTH-1:0] res_hi, res_lo;
    logic             div_zero;

    assign op_in = md_op_e'(md_op);

    md_arith #(.WIDTH(WIDTH)) u_arith (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .hi_next  (res_hi),
        .lo_next  (res_lo),
        .div_zero (div_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= MD_NONE;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            op_q  <= op_n;
            a_q   <= a_n;
            b_q   <= b_n;
            hi    <= hi_n;
            lo    <= lo_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        op_n    = op_q;
        a_n     = a_q;
        b_n     = b_q;
        hi_n    = hi;
        lo_n    = lo;
        busy_n  = busy;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (is_long_op(op_in)) begin
                        op_n    = op_in;
                        a_n     = A;
                        b_n     = B;
                        cnt_n   = (op_in == MD_MULT || op_in == MD_MULTU) ?
                                  CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        state_n = RUN;
                        busy_n  = 1'b1;
                    end else if (op_in == MD_MTHI) begin
                        hi_n = A;
                    end else if (op_in == MD_MTLO) begin
                        lo_n = A;
                    end
                end
            end
            RUN: begin
                // start is ignored here; the hazard unit never issues while busy.
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    if (!(div_zero && (op_q == MD_DIV || op_q == MD_DIVU))) begin
                        hi_n = res_hi;
                        lo_n = res_lo;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed self-checking bench for md_unit
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        tick();
        start = 1'b0;
        md_op = 3'd0;
    endtask

    // Issues a long op and returns in the first cycle busy is low again; A/B are scrambled meanwhile.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cnt;
        issue(op, a, b);
        check({tag, " busy rise"}, 32'(busy), 32'd1);
        check({tag, " done at rise"}, 32'(done), 32'd0);
        cnt = 0;
        while (busy && cnt < 50) begin
            A = $urandom;
            B = $urandom;
            cnt++;
            tick();
        end
        check({tag, " busy cycles"}, 32'(cnt), 32'(n));
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
    endtask

    initial begin
        // reset
        reset = 1'b0;
        tick();
        tick();
        check("rst hi", hi, 32'h0);
        check("rst lo", lo, 32'h0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        reset = 1'b1;
        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrun rst busy", 32'(busy), 32'd0);
        for (int i = 0; i < 6; i++) tick();
        check("midrun rst done", 32'(done), 32'd0);
        check("midrun rst hi", hi, 32'h0);
        check("midrun rst lo", lo, 32'h0);

        // multiply
        run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        tick();
        check("mult done pulse", 32'(done), 32'd0);
        run_op("multu", 3'd2, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);

        // divide
        run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", 3'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
        run_op("div ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);

        issue(3'd5, 32'd5, 32'd0);
        issue(3'd6, 32'd9, 32'd0);
        run_op("divu by0", 3'd4, 32'd123, 32'd0, 10, 32'd5, 32'd9);

        // none / reserved ops
        issue(3'd0, 32'hAAAA_AAAA, 32'd1);
        check("none busy", 32'(busy), 32'd0);
        issue(3'd7, 32'hAAAA_AAAA, 32'd1);
        check("rsvd busy", 32'(busy), 32'd0);
        check("rsvd hi", hi, 32'd5);
        check("rsvd lo", lo, 32'd9);

        // mthi / mtlo back-to-back
        issue(3'd5, 32'h1234_5678, 32'd0);
        check("mthi hi", hi, 32'h1234_5678);
        check("mthi busy", 32'(busy), 32'd0);
        issue(3'd6, 32'h9ABC_DEF0, 32'd0);
        check("mtlo lo", lo, 32'h9ABC_DEF0);
        check("mtlo hi", hi, 32'h1234_5678);
        check("mtlo busy", 32'(busy), 32'd0);
        tick();
        check("mtx done", 32'(done), 32'd0);

        // mthi while busy is ignored
        issue(3'd1, 32'd100, 32'd200);
        tick();
        issue(3'd5, 32'hDEAD_BEEF, 32'd0);
        check("mthi inrun hi", hi, 32'h1234_5678);
        for (int i = 0; i < 3; i++) tick();
        check("mthi inrun done", 32'(done), 32'd1);
        check("mthi inrun hi final", hi, 32'h0);
        check("mthi inrun lo final", lo, 32'h0000_4E20);

        // back-to-back: issue in the cycle busy falls
        run_op("b2b first", 3'd1, 32'd7, 32'd6, 5, 32'h0, 32'd42);
        run_op("b2b second", 3'd2, 32'd5, 32'd5, 5, 32'h0, 32'd25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers for the EX stage of the 5-stage pipeline.
- Executes mult, multu, div, divu, mthi and mtlo.
- Exposes a registered busy flag. The hazard unit combines busy with start to stall later multiply/divide and mfhi/mflo instructions held in ID.
- mfhi and mflo read the hi/lo outputs directly.

Parameters:
WIDTH, 32, operand and HI/LO width.
MULT_CYCLES, 5, busy cycles for mult/multu; must be >= 1.
DIV_CYCLES, 10, busy cycles for div/divu; must be >= 1.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-low reset.
start  in  1  one-cycle request; md_op, A and B are valid in the same cycle.
md_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 is reserved and treated as none.
A  in  WIDTH  rs operand, already forwarded.
B  in  WIDTH  rt operand, already forwarded.
busy  out  1  registered; high while a mult or div is in flight.
done  out  1  registered one-cycle pulse in the cycle HI/LO first show a new mult/div result.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset==0 at a clock edge):
  - hi, lo, busy, done, counter and pending-op all go to 0.
  - Overrides any in-flight operation; that result is discarded.
- FSM states: IDLE, RUN.
- IDLE, start with mult/multu/div/divu:
  - Capture A, B and the op.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; busy=1 from the next cycle.
- IDLE, start with mthi/mtlo:
  - hi<=A (mthi) or lo<=A (mtlo) at that edge.
  - busy stays 0 and done stays 0.
- RUN:
  - Counter decrements each edge.
  - At the edge where the counter==1, write hi/lo and pulse done. State returns to IDLE and busy drops at that same edge.
  - busy is therefore high for exactly N cycles after the start edge; the result is visible in cycle N+1 (start edge = cycle 0).
- start while busy: ignored, including mthi/mtlo. The hazard unit guarantees this never happens; the bench checks it is harmless.
- Operands are captured at start. Changes on A/B during RUN have no effect.
- start with md_op none/reserved: no state change.
- Arithmetic:
  - mult: signed WIDTH×WIDTH→2·WIDTH product; hi=upper half, lo=lower half.
  - multu: same, unsigned.
  - div: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
- Boundaries:
  - Divide by zero (div/divu, B==0): full busy latency still applies; hi/lo keep their previous values; done still pulses.
  - div with A=most-negative, B=-1: lo=most-negative (wraps), hi=0.
  - Result computation may be combinational at completion; there is no partial-result exposure.
- done is never high in the same cycle as busy rising.

Decomposition:
- Shared package md_defs:
  - MD_NONE..MD_MTLO op encoding constants.
  - State encoding IDLE/RUN.
  - Counter width function clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- Controller gains an md_op decode output using the same constants.
- One natural sub-module: md_arith, a combinational signed/unsigned multiply and divide producing {hi_next, lo_next}, plus a divide-by-zero flag.
- md_unit holds the FSM, counter, operand capture and HI/LO registers.

Test Plan:
All scenarios use WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10.
1. Reset: hold reset=0 for 2 cycles -> hi=lo=0, busy=0, done=0. Then mult start with reset=0 mid-RUN (cycle 3) -> busy=0 next cycle, hi/lo stay 0.
2. mult: A=0xFFFFFFFE (-2), B=3 -> busy high for cycles 1-5; cycle 6 shows hi=0xFFFFFFFF, lo=0xFFFFFFFA, done=1 for one cycle. multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
3. div: A=-7, B=2 -> after 10 busy cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu: A=7, B=2 -> lo=3, hi=1.
4. Corner divisions:
   - div A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
   - divu with B=0 after hi=5, lo=9 -> busy 10 cycles, done pulses, hi=5 and lo=9 unchanged.
5. mthi/mtlo: mthi A=0x12345678 then mtlo A=0x9ABCDEF0 on consecutive cycles -> hi/lo update the cycle after each, busy never rises. mthi issued during a RUN -> ignored, final hi equals the mult result.
6. Back-to-back: start a new mult in the cycle busy falls -> accepted. A/B toggled during RUN -> result reflects the captured operands only.
